// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e      : arbiter owner encoding (IDLE/CPU/LDR)
//   STARVE_LIMIT_DEF : default number of CPU-won conflict cycles before the
//                      loader is force-granted
//   sat_inc16        : saturating 16-bit increment used by the conflict counter
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_LDR  = 2'd2
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the loader/debug port, dmem and the
// arbiter.
//   cpu_*        : CPU request side (req/we/addr/wdata in, rdata/stall out)
//   ld_*         : loader request side (req/we/addr/wdata in,
//                  gnt/rvalid/rdata out)
//   mem_*        : dmem side (we/addr/data out, mem_out in)
//   conflict_cnt : saturating count of cycles with both requesters active
// Modport arb is taken by the arbiter, env by everything around it.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    logic [15:0]   conflict_cnt;

    modport arb (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_we, mem_addr, mem_data,
        input  mem_out,
        output conflict_cnt
    );

    modport env (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_we, mem_addr, mem_data,
        output mem_out,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipelined CPU data port and a
// loader/debug port, in front of a dmem with synchronous write and
// combinational read.
//   clk : single clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : dmem_arbiter_if.arb (CPU, loader, dmem and conflict counter)
// The CPU normally wins; after STARVE_LIMIT consecutive CPU-won conflict
// cycles the loader is granted for one cycle. Grants are decided
// combinationally every cycle, so ownership switches without a bubble and a
// CPU alone sees dmem directly.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.arb    bus
);

    arb_state_e            state_reg, state_next;
    logic [STARVE_W-1:0]   starve_reg, starve_next;
    logic [15:0]           conflict_reg, conflict_next;
    logic [DW-1:0]         ld_rdata_reg, ld_rdata_next;
    logic                  ld_rd_reg, ld_rd_next;

    logic                  force_ld;
    logic                  mem_we_raw;
    logic [AW-1:0]         mem_addr_raw;
    logic [DW-1:0]         mem_data_raw;

    // State register: owner of the previous cycle plus loader read tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            starve_reg   <= '0;
            conflict_reg <= '0;
            ld_rdata_reg <= '0;
            ld_rd_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            starve_reg   <= starve_next;
            conflict_reg <= conflict_next;
            ld_rdata_reg <= ld_rdata_next;
            ld_rd_reg    <= ld_rd_next;
        end
    end

    // Next owner and datapath. The flop inputs never look at rst; reset only
    // gates the outputs below so the bus is quiet while rst is low.
    always_comb begin
        force_ld      = (starve_reg == STARVE_W'(STARVE_LIMIT)) && bus.ld_req;
        state_next    = ST_IDLE;
        mem_we_raw    = 1'b0;
        mem_addr_raw  = '0;
        mem_data_raw  = '0;
        starve_next   = starve_reg;
        conflict_next = conflict_reg;
        ld_rd_next    = 1'b0;
        ld_rdata_next = ld_rdata_reg;

        if (force_ld) begin
            state_next = ST_LDR;
        end else if (bus.cpu_req) begin
            state_next = ST_CPU;
        end else if (bus.ld_req) begin
            state_next = ST_LDR;
        end

        case (state_next)
            ST_CPU: begin
                mem_we_raw   = bus.cpu_we;
                mem_addr_raw = bus.cpu_addr;
                mem_data_raw = bus.cpu_wdata;
            end
            ST_LDR: begin
                mem_we_raw   = bus.ld_we;
                mem_addr_raw = bus.ld_addr;
                mem_data_raw = bus.ld_wdata;
            end
            default: ;
        endcase

        // Starvation counter only runs while the loader is actually waiting.
        if (state_next == ST_LDR || !bus.ld_req) begin
            starve_next = '0;
        end else if (state_next == ST_CPU) begin
            starve_next = starve_reg + 1'b1;
        end

        if (bus.cpu_req && bus.ld_req) begin
            conflict_next = sat_inc16(conflict_reg);
        end

        // Granted loader read: dmem read is combinational, so capture now.
        if (state_next == ST_LDR && !bus.ld_we) begin
            ld_rd_next    = 1'b1;
            ld_rdata_next = bus.mem_out;
        end
    end

    assign bus.mem_we       = rst & mem_we_raw;
    assign bus.mem_addr     = rst ? mem_addr_raw : '0;
    assign bus.mem_data     = rst ? mem_data_raw : '0;
    assign bus.ld_gnt       = rst & (state_next == ST_LDR);
    assign bus.cpu_stall    = rst & bus.cpu_req & (state_next != ST_CPU);
    assign bus.cpu_rdata    = bus.mem_out;

    // Read data is valid the cycle after the loader owned dmem for a read.
    assign bus.ld_rvalid    = (state_reg == ST_LDR) & ld_rd_reg;
    assign bus.ld_rdata     = ld_rdata_reg;
    assign bus.conflict_cnt = conflict_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // dmem model: synchronous write, combinational read, word per address LSBs
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_data;
    end
    assign bus.mem_out = mem[bus.mem_addr[7:0]];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wd;
        logic        l_req, l_we;
        logic [31:0] l_addr, l_wd;
        logic        e_stall, e_gnt, e_we;
        logic [31:0] e_addr, e_data;
        logic        chk_crd;
        logic [31:0] e_crd;
        logic        e_rv;
        logic [31:0] e_lrd;
        logic [15:0] e_cf;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(
        input logic c_req, c_we, input logic [31:0] c_addr, c_wd,
        input logic l_req, l_we, input logic [31:0] l_addr, l_wd,
        input logic e_stall, e_gnt, e_we, input logic [31:0] e_addr, e_data,
        input logic chk_crd, input logic [31:0] e_crd,
        input logic e_rv, input logic [31:0] e_lrd, input logic [15:0] e_cf);
        vec_t v;
        v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
        v.l_req = l_req; v.l_we = l_we; v.l_addr = l_addr; v.l_wd = l_wd;
        v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_we = e_we;
        v.e_addr = e_addr; v.e_data = e_data;
        v.chk_crd = chk_crd; v.e_crd = e_crd;
        v.e_rv = e_rv; v.e_lrd = e_lrd; v.e_cf = e_cf;
        return v;
    endfunction

    task automatic drive(input logic c_req, c_we, input logic [31:0] c_addr, c_wd,
                         input logic l_req, l_we, input logic [31:0] l_addr, l_wd);
        bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
        bus.ld_req = l_req; bus.ld_we = l_we; bus.ld_addr = l_addr; bus.ld_wdata = l_wd;
    endtask

    localparam logic [11:0] EXP_L = 12'h210;   // L on cycles 5 and 10 (bit0 = cycle 1)

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        //        creq cwe addr   wdata          lreq lwe addr   wdata         stall gnt we addr   data           chk crd            rv lrd            cf
        vecs[0] = mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        16'd0);
        vecs[1] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        16'd0);
        vecs[2] = mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h10, 32'h0,        0, 1, 0, 32'h10, 32'h0,        0, 32'h0,        1, 32'hDEADBEEF, 16'd0);
        vecs[3] = mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 32'hDEADBEEF, 16'd0);
        vecs[4] = mk(0, 0, 32'h00, 32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 1, 32'h20, 32'h12345678, 0, 32'h0,        0, 32'hDEADBEEF, 16'd0);
        vecs[5] = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h20, 32'h0,        1, 32'h12345678, 0, 32'hDEADBEEF, 16'd0);
        vecs[6] = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 16'd1);
        vecs[7] = mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 32'h0,        0, 32'h0,        1, 32'h12345678, 16'd1);
        vecs[8] = mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 32'h12345678, 16'd1);

        // Reset state, with a CPU write pending that must not reach dmem
        drive(1, 1, 32'h10, 32'hBAD0BAD0, 1, 1, 32'h10, 32'hBAD1BAD1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'h0);
        chk("rst_ld_rdata", bus.ld_rdata, 32'h0);
        chk("rst_conflict", 32'(bus.conflict_cnt), 32'h0);
        $display("reset: mem_we=%b ld_gnt=%b cpu_stall=%b conflict=%0d",
                 bus.mem_we, bus.ld_gnt, bus.cpu_stall, bus.conflict_cnt);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Table-driven single-cycle transactions
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd,
                  vecs[i].l_req, vecs[i].l_we, vecs[i].l_addr, vecs[i].l_wd);
            #2;
            chk($sformatf("v%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ld_gnt", i), 32'(bus.ld_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_mem_data", i), bus.mem_data, vecs[i].e_data);
            if (vecs[i].chk_crd) chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].e_crd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ld_rvalid", i), 32'(bus.ld_rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_ld_rdata", i), bus.ld_rdata, vecs[i].e_lrd);
            chk($sformatf("v%0d_conflict", i), 32'(bus.conflict_cnt), 32'(vecs[i].e_cf));
            $display("vec %0d: stall=%b gnt=%b we=%b addr=%h rvalid=%b ld_rdata=%h conflict=%0d",
                     i, bus.cpu_stall, bus.ld_gnt, bus.mem_we, bus.mem_addr,
                     bus.ld_rvalid, bus.ld_rdata, bus.conflict_cnt);
        end

        // Reset asserted in the middle of a granted loader read
        drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h10, 32'h0);
        force_ld_read_cycle();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_rvalid_%0d", i), 32'(bus.ld_rvalid), 32'h0);
        end
        chk("post_rst_conflict", 32'(bus.conflict_cnt), 32'h0);
        $display("reset mid-read: rvalid=%b conflict=%0d", bus.ld_rvalid, bus.conflict_cnt);

        // Sustained conflict: expect CCCCLCCCCLCC
        drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) chk($sformatf("starve_rvalid_c%0d", i + 1), 32'(bus.ld_rvalid), 32'(EXP_L[i-1]));
            #2;
            chk($sformatf("starve_gnt_c%0d", i + 1), 32'(bus.ld_gnt), 32'(EXP_L[i]));
            chk($sformatf("starve_stall_c%0d", i + 1), 32'(bus.cpu_stall), 32'(EXP_L[i]));
            $display("starve cycle %0d: owner=%s stall=%b", i + 1,
                     bus.ld_gnt ? "L" : "C", bus.cpu_stall);
            @(posedge clk);
            #1;
        end
        chk("starve_conflict", 32'(bus.conflict_cnt), 32'd12);

        // Saturation of the conflict counter
        repeat (65523) @(posedge clk);
        #1;
        chk("sat_at_max", 32'(bus.conflict_cnt), 32'h0000FFFF);
        repeat (4465) @(posedge clk);
        #1;
        chk("sat_after_70000", 32'(bus.conflict_cnt), 32'h0000FFFF);
        $display("saturation: conflict=%h", bus.conflict_cnt);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Loader read granted in the current cycle (CPU dropped), then rst pulled
    // low before the capturing edge; reset gating must act immediately.
    task automatic force_ld_read_cycle();
        bus.cpu_req = 1'b0;
        #2;
        chk("midrd_ld_gnt", 32'(bus.ld_gnt), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrd_ld_gnt_rst", 32'(bus.ld_gnt), 32'h0);
        chk("midrd_mem_we_rst", 32'(bus.mem_we), 32'h0);
        bus.ld_we = 1'b1;
        bus.cpu_req = 1'b1;
        #0.5;
        chk("midrd_wr_mem_we_rst", 32'(bus.mem_we), 32'h0);
        chk("midrd_cpu_stall_rst", 32'(bus.cpu_stall), 32'h0);
        chk("midrd_conflict_rst", 32'(bus.conflict_cnt), 32'h0);
        chk("midrd_rvalid_rst", 32'(bus.ld_rvalid), 32'h0);
    endtask

endmodule
